// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
//   slot_t      : one in-flight writer record {valid, rd, we, load}
//   REG_AW      : architectural register address width
//   ready_stage : stages after decode at which a producer's result can be forwarded
package hz_pkg;

  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } slot_t;

  // Non-loads forward from EX/MEM (stage 1); loads need LOAD_LAT more stages.
  function automatic int unsigned ready_stage(input logic load, input int unsigned load_lat);
    return load ? (32'd1 + load_lat) : 32'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard.
//   master : pipeline control / decode stage (drives freeze, flush, id_*)
//   slave  : hazard_scoreboard (drives hz_stall, fwd_a, fwd_b, stall_cnt)
interface hazard_scoreboard_if #(
  parameter int unsigned FW = 2
);
  import hz_pkg::*;

  logic              freeze;
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_load;
  logic              hz_stall;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic [31:0]       stall_cnt;

  modport master (
    output freeze, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_load,
    input  hz_stall, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  freeze, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_load,
    output hz_stall, fwd_a, fwd_b, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Youngest-match priority finder over the scoreboard slots for one source operand.
//   slots   : scoreboard, index 0 = youngest (EX)
//   src     : source register address; use_src : operand actually read
//   hit     : some valid writer of src is in flight (never for x0)
//   idx     : slot index of the youngest such writer
//   is_load : that writer is a load
module hz_match
  import hz_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  slot_t             slots [DEPTH],
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  output logic              hit,
  output logic [IW-1:0]     idx,
  output logic              is_load
);

  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    if (use_src && (src != '0)) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (slots[k].valid && slots[k].we && (slots[k].rd == src)) begin
          hit     = 1'b1;
          idx     = IW'(k);
          is_load = slots[k].load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and stall controller beside the decode stage.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of hazard_scoreboard_if
//              in : freeze, flush, id_valid, id_rs1/2, id_use_rs1/2, id_rd, id_we, id_load
//              out: hz_stall (combinational), fwd_a/fwd_b (registered), stall_cnt (saturating)
module hazard_scoreboard
  import hz_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned FW       = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);

  slot_t         slots_q [DEPTH];
  logic [FW-1:0] fwd_a_q;
  logic [FW-1:0] fwd_b_q;
  logic [31:0]   stall_cnt_q;

  logic          hit_a_c, hit_b_c;
  logic [FW-1:0] idx_a_c, idx_b_c;
  logic          load_a_c, load_b_c;
  logic          haz_a_c, haz_b_c;
  logic [FW-1:0] sel_a_c, sel_b_c;
  logic          hz_stall_c;
  logic          enter_c;
  slot_t         new_slot_c;

  hz_match #(.DEPTH(DEPTH), .IW(FW)) u_match_a (
    .slots   (slots_q),
    .src     (bus.id_rs1),
    .use_src (bus.id_use_rs1),
    .hit     (hit_a_c),
    .idx     (idx_a_c),
    .is_load (load_a_c)
  );

  hz_match #(.DEPTH(DEPTH), .IW(FW)) u_match_b (
    .slots   (slots_q),
    .src     (bus.id_rs2),
    .use_src (bus.id_use_rs2),
    .hit     (hit_b_c),
    .idx     (idx_b_c),
    .is_load (load_b_c)
  );

  // Hazard if the producer is not yet at its forwarding point; without a
  // forwarding network only the WB slot (write-before-read regfile) is safe.
  function automatic logic src_hazard(input logic hit, input logic [FW-1:0] idx,
                                      input logic load);
    if (!hit) return 1'b0;
    if (FWD_EN) return (32'(idx) + 32'd1) < ready_stage(load, LOAD_LAT);
    return 32'(idx) < (DEPTH - 32'd1);
  endfunction

  // Forward from stage idx+1 unless the producer is already in WB.
  function automatic logic [FW-1:0] src_select(input logic hit, input logic [FW-1:0] idx);
    if (FWD_EN && hit && (32'(idx) < (DEPTH - 32'd1))) return FW'(32'(idx) + 32'd1);
    return '0;
  endfunction

  // Stall decision and next slot-0 contents.
  always_comb begin
    haz_a_c    = src_hazard(hit_a_c, idx_a_c, load_a_c);
    haz_b_c    = src_hazard(hit_b_c, idx_b_c, load_b_c);
    sel_a_c    = src_select(hit_a_c, idx_a_c);
    sel_b_c    = src_select(hit_b_c, idx_b_c);
    hz_stall_c = bus.id_valid & ~bus.flush & (haz_a_c | haz_b_c);
    enter_c    = bus.id_valid & ~hz_stall_c & ~bus.flush;
    new_slot_c = '0;
    if (enter_c) begin
      new_slot_c.valid = 1'b1;
      new_slot_c.rd    = bus.id_rd;
      new_slot_c.we    = bus.id_we & (bus.id_rd != '0);
      new_slot_c.load  = bus.id_load;
    end
  end

  // Slot shift register, EX forwarding selects and stall counter; freeze holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) slots_q[i] <= '0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
    end else if (!bus.freeze) begin
      for (int i = int'(DEPTH) - 1; i >= 1; i--) slots_q[i] <= slots_q[i-1];
      slots_q[0] <= new_slot_c;
      fwd_a_q    <= enter_c ? sel_a_c : '0;
      fwd_b_q    <= enter_c ? sel_b_c : '0;
      if (hz_stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.hz_stall  = hz_stall_c;
  assign bus.fwd_a     = fwd_a_q;
  assign bus.fwd_b     = fwd_b_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: three scoreboards (DEPTH=3) side by side.
//   inst 0: LOAD_LAT=1, FWD_EN=1   inst 1: LOAD_LAT=1, FWD_EN=0   inst 2: LOAD_LAT=2, FWD_EN=1
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  localparam int unsigned NI = 3;
  localparam int unsigned D  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NI-1:0]       d_valid, d_flush, d_freeze, d_use1, d_use2, d_we, d_load;
  logic [NI-1:0][4:0]  d_rs1, d_rs2, d_rd;
  logic [NI-1:0]       o_stall;
  logic [NI-1:0][1:0]  o_fa, o_fb;
  logic [NI-1:0][31:0] o_cnt;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    hazard_scoreboard_if #(.FW(2)) bus ();
    assign bus.freeze     = d_freeze[g];
    assign bus.flush      = d_flush[g];
    assign bus.id_valid   = d_valid[g];
    assign bus.id_rs1     = d_rs1[g];
    assign bus.id_rs2     = d_rs2[g];
    assign bus.id_use_rs1 = d_use1[g];
    assign bus.id_use_rs2 = d_use2[g];
    assign bus.id_rd      = d_rd[g];
    assign bus.id_we      = d_we[g];
    assign bus.id_load    = d_load[g];
    assign o_stall[g]     = bus.hz_stall;
    assign o_fa[g]        = bus.fwd_a;
    assign o_fb[g]        = bus.fwd_b;
    assign o_cnt[g]       = bus.stall_cnt;
    hazard_scoreboard #(
      .DEPTH(D), .LOAD_LAT((g == 2) ? 2 : 1), .FWD_EN((g == 1) ? 1'b0 : 1'b1)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
  end

  function automatic int ll_of(int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic bit fe_of(int i);
    return (i != 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    d_valid = '0; d_flush = '0; d_freeze = '0; d_use1 = '0; d_use2 = '0;
    d_we = '0; d_load = '0; d_rs1 = '0; d_rs2 = '0; d_rd = '0;
  endtask

  task automatic put(int i, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                     logic u1, logic u2, logic we, logic ld);
    d_valid[i] = 1'b1; d_rd[i] = rd; d_rs1[i] = rs1; d_rs2[i] = rs2;
    d_use1[i] = u1; d_use2[i] = u2; d_we[i] = we; d_load[i] = ld;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NI; i++) begin
      put(i, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      checks++; if (o_stall[i] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d] got %0b want 0", i, o_stall[i]); end
      checks++; if (o_fa[i] !== 2'd0) begin errors++; $display("FAIL reset_fwd_a[%0d] got %0d want 0", i, o_fa[i]); end
      checks++; if (o_fb[i] !== 2'd0) begin errors++; $display("FAIL reset_fwd_b[%0d] got %0d want 0", i, o_fb[i]); end
      checks++; if (o_cnt[i] !== 32'd0) begin errors++; $display("FAIL reset_cnt[%0d] got %0d want 0", i, o_cnt[i]); end
    end
    idle_all();
  endtask

  // Producer of x5 then consumer x6 <- x5, rs2; count stall cycles and check selects.
  task automatic test_dependency(int i, logic prod_load, logic [4:0] rs2, int exp_cycles,
                                 logic [1:0] exp_fa, logic [1:0] exp_fb, string name);
    int n;
    do_reset();
    put(i, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, prod_load);
    tick();
    put(i, 5'd6, 5'd5, rs2, 1'b1, 1'b1, 1'b1, 1'b0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!o_stall[i]) break;
      n++;
      tick();
    end
    checks++; if (n != exp_cycles) begin errors++; $display("FAIL %s stall_cycles got %0d want %0d", name, n, exp_cycles); end
    tick();
    idle_all();
    #1;
    checks++; if (o_fa[i] !== exp_fa) begin errors++; $display("FAIL %s fwd_a got %0d want %0d", name, o_fa[i], exp_fa); end
    checks++; if (o_fb[i] !== exp_fb) begin errors++; $display("FAIL %s fwd_b got %0d want %0d", name, o_fb[i], exp_fb); end
    checks++; if (o_cnt[i] !== 32'(exp_cycles)) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", name, o_cnt[i], exp_cycles); end
  endtask

  // Producer of x5 at distance 1..3 (non-writers between), consumer reads x5.
  task automatic test_distance();
    logic [1:0] exp;
    for (int gap = 1; gap <= 3; gap++) begin
      do_reset();
      put(0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      for (int g = 1; g < gap; g++) begin
        put(0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
      end
      put(0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      checks++; if (o_stall[0] !== 1'b0) begin errors++; $display("FAIL dist%0d stall got %0b want 0", gap, o_stall[0]); end
      tick();
      idle_all();
      #1;
      exp = (gap < int'(D)) ? 2'(gap) : 2'd0;
      checks++; if (o_fa[0] !== exp) begin errors++; $display("FAIL dist%0d fwd_a got %0d want %0d", gap, o_fa[0], exp); end
    end
  endtask

  task automatic test_youngest();
    do_reset();
    put(0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    put(0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    put(0, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    idle_all();
    #1;
    checks++; if (o_fa[0] !== 2'd1) begin errors++; $display("FAIL youngest fwd_a got %0d want 1", o_fa[0]); end
    checks++; if (o_fb[0] !== 2'd1) begin errors++; $display("FAIL youngest fwd_b got %0d want 1", o_fb[0]); end
  endtask

  task automatic test_x0();
    do_reset();
    put(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    put(0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (o_stall[0] !== 1'b0) begin errors++; $display("FAIL x0 stall got %0b want 0", o_stall[0]); end
    tick();
    idle_all();
    #1;
    checks++; if (o_fa[0] !== 2'd0 || o_fb[0] !== 2'd0) begin errors++; $display("FAIL x0 fwd got %0d/%0d want 0/0", o_fa[0], o_fb[0]); end
    put(0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    put(0, 5'd6, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (o_stall[0] !== 1'b0) begin errors++; $display("FAIL unused_src stall got %0b want 0", o_stall[0]); end
    idle_all();
  endtask

  task automatic test_flush();
    do_reset();
    put(0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    put(0, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    put(0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    d_flush[0] = 1'b1;
    #1;
    checks++; if (o_stall[0] !== 1'b0) begin errors++; $display("FAIL flush stall got %0b want 0", o_stall[0]); end
    checks++; if (o_fa[0] !== 2'd1) begin errors++; $display("FAIL flush load_fwd_a got %0d want 1", o_fa[0]); end
    tick();
    d_flush[0] = 1'b0;
    put(0, 5'd7, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (o_fa[0] !== 2'd0) begin errors++; $display("FAIL flush bubble_fwd_a got %0d want 0", o_fa[0]); end
    tick();
    idle_all();
    #1;
    checks++; if (o_fa[0] !== 2'd0) begin errors++; $display("FAIL flush killed_rd fwd_a got %0d want 0", o_fa[0]); end
  endtask

  task automatic test_freeze();
    do_reset();
    put(0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    put(0, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    put(0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    d_freeze[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      d_flush[0] = (c == 3);
      #1;
      checks++; if (o_stall[0] !== 1'(c != 3)) begin errors++; $display("FAIL freeze%0d stall got %0b want %0b", c, o_stall[0], c != 3); end
      checks++; if (o_fa[0] !== 2'd1) begin errors++; $display("FAIL freeze%0d fwd_a got %0d want 1", c, o_fa[0]); end
      checks++; if (o_cnt[0] !== 32'd0) begin errors++; $display("FAIL freeze%0d cnt got %0d want 0", c, o_cnt[0]); end
      tick();
    end
    d_freeze[0] = 1'b0;
    d_flush[0]  = 1'b0;
    #1;
    checks++; if (o_stall[0] !== 1'b1) begin errors++; $display("FAIL thaw stall got %0b want 1", o_stall[0]); end
    tick();
    #1;
    checks++; if (o_stall[0] !== 1'b0) begin errors++; $display("FAIL thaw resolve stall got %0b want 0", o_stall[0]); end
    checks++; if (o_cnt[0] !== 32'd1) begin errors++; $display("FAIL thaw cnt got %0d want 1", o_cnt[0]); end
    tick();
    idle_all();
    #1;
    checks++; if (o_fa[0] !== 2'd2) begin errors++; $display("FAIL thaw fwd_a got %0d want 2", o_fa[0]); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    put(0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    put(0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (o_stall[0] !== 1'b1) begin errors++; $display("FAIL midrst pre stall got %0b want 1", o_stall[0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (o_stall[0] !== 1'b0) begin errors++; $display("FAIL midrst stall got %0b want 0", o_stall[0]); end
    checks++; if (o_cnt[0] !== 32'd0) begin errors++; $display("FAIL midrst cnt got %0d want 0", o_cnt[0]); end
    idle_all();
  endtask

  // Reference model: per instance, the writers in flight listed by distance from decode.
  logic        m_v    [NI][D+1];
  logic [4:0]  m_rd   [NI][D+1];
  logic        m_we   [NI][D+1];
  logic        m_ld   [NI][D+1];
  logic [1:0]  m_fa   [NI];
  logic [1:0]  m_fb   [NI];
  logic [31:0] m_cnt  [NI];

  task automatic model_src(int i, logic [4:0] s, logic u, output logic haz, output logic [1:0] sel);
    int need;
    haz = 1'b0;
    sel = 2'd0;
    if (u && s != 5'd0) begin
      for (int d = 1; d <= int'(D); d++) begin
        if (m_v[i][d] && m_we[i][d] && m_rd[i][d] == s) begin
          need = m_ld[i][d] ? 1 + ll_of(i) : 1;
          if (fe_of(i)) begin
            haz = (d < need);
            sel = (d < int'(D)) ? 2'(d) : 2'd0;
          end else begin
            haz = (d < int'(D));
          end
          break;
        end
      end
    end
  endtask

  task automatic test_random(int cycles);
    logic ha, hb, st, enter;
    logic [1:0] sa, sb;
    do_reset();
    for (int i = 0; i < NI; i++) begin
      for (int d = 0; d <= int'(D); d++) begin
        m_v[i][d] = 1'b0; m_rd[i][d] = 5'd0; m_we[i][d] = 1'b0; m_ld[i][d] = 1'b0;
      end
      m_fa[i] = 2'd0; m_fb[i] = 2'd0; m_cnt[i] = 32'd0;
    end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NI; i++) begin
        d_valid[i]  = ($urandom_range(0, 3) != 0);
        d_rs1[i]    = 5'($urandom_range(0, 3));
        d_rs2[i]    = 5'($urandom_range(0, 3));
        d_rd[i]     = 5'($urandom_range(0, 3));
        d_use1[i]   = ($urandom_range(0, 4) != 0);
        d_use2[i]   = ($urandom_range(0, 2) != 0);
        d_we[i]     = ($urandom_range(0, 9) < 7);
        d_load[i]   = ($urandom_range(0, 9) < 3);
        d_flush[i]  = ($urandom_range(0, 9) == 0);
        d_freeze[i] = ($urandom_range(0, 7) == 0);
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        model_src(i, d_rs1[i], d_use1[i], ha, sa);
        model_src(i, d_rs2[i], d_use2[i], hb, sb);
        st = d_valid[i] && !d_flush[i] && (ha || hb);
        checks++; if (o_stall[i] !== st) begin errors++; $display("FAIL rnd c%0d i%0d stall got %0b want %0b", c, i, o_stall[i], st); end
        checks++; if (o_fa[i] !== m_fa[i] || o_fb[i] !== m_fb[i]) begin errors++; $display("FAIL rnd c%0d i%0d fwd got %0d/%0d want %0d/%0d", c, i, o_fa[i], o_fb[i], m_fa[i], m_fb[i]); end
        checks++; if (o_cnt[i] !== m_cnt[i]) begin errors++; $display("FAIL rnd c%0d i%0d cnt got %0d want %0d", c, i, o_cnt[i], m_cnt[i]); end
        if (!d_freeze[i]) begin
          enter = d_valid[i] && !st && !d_flush[i];
          for (int d = int'(D); d >= 2; d--) begin
            m_v[i][d] = m_v[i][d-1]; m_rd[i][d] = m_rd[i][d-1];
            m_we[i][d] = m_we[i][d-1]; m_ld[i][d] = m_ld[i][d-1];
          end
          m_v[i][1]  = enter;
          m_rd[i][1] = d_rd[i];
          m_we[i][1] = d_we[i] && d_rd[i] != 5'd0;
          m_ld[i][1] = d_load[i];
          m_fa[i] = enter ? sa : 2'd0;
          m_fb[i] = enter ? sb : 2'd0;
          if (st && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
        end
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_dependency(0, 1'b0, 5'd1, 0, 2'd1, 2'd0, "fwd_add");
    test_dependency(0, 1'b1, 5'd1, 1, 2'd2, 2'd0, "load_use_ll1");
    test_dependency(2, 1'b1, 5'd1, 2, 2'd0, 2'd0, "load_use_ll2");
    test_dependency(1, 1'b0, 5'd5, 2, 2'd0, 2'd0, "nofwd_sub");
    test_distance();
    test_youngest();
    test_x0();
    test_flush();
    test_freeze();
    test_reset_mid_stall();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard, forwarding and stall controller for the RISC-V lite pipeline, sitting beside the decode stage. It tracks every in-flight register writer in a shift scoreboard of configurable depth, resolves load-use and no-forwarding hazards generically via a load-latency parameter, and supports branch flush and global freeze. It also produces registered forwarding selects for the EX stage and keeps a saturating stall-cycle counter.

## Interface
- DEPTH, 3: number of post-decode stages that can hold a writer (slot 0 = EX, slot DEPTH-1 = WB); legal 2..8.
- LOAD_LAT, 1: extra stages after EX before load data can be forwarded; legal 0..DEPTH-1.
- FWD_EN, 1: 1 = forwarding network present; 0 = register-file-only operand delivery.
- FW, $clog2(DEPTH): width of forwarding selects.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- freeze  in  1  global hold (memory stall or pipeline disable); all state held.
- flush  in  1  branch/jump taken in EX; instruction in decode is killed.
- id_valid  in  1  decode holds a real instruction.
- id_rs1, id_rs2  in  5 each  decode source register addresses.
- id_use_rs1, id_use_rs2  in  1 each  source actually read.
- id_rd  in  5  decode destination register.
- id_we  in  1  decode instruction writes rd.
- id_load  in  1  decode instruction is a load.
- hz_stall  out  1  combinational; hold PC and IF/ID, insert bubble into EX.
- fwd_a, fwd_b  out  FW  registered; operand source for instruction now in EX: 0 = register file, n = result of stage n after EX (1 = EX/MEM, 2 = MEM/WB, ...).
- stall_cnt  out  32  cycles with hz_stall=1 and freeze=0, saturating.

## Operation
- Scoreboard: DEPTH slots of {valid, rd, we, load}. Slot k holds the instruction k+1 stages ahead of decode.
- Match for a source s: youngest slot k with valid & we & rd==s, s!=0, use bit set. Older matches are ignored.
- Ready stage per producer: r = 1 for non-loads, r = 1+LOAD_LAT for loads.
- FWD_EN=1: source hazard when a match has k+1 < r. Select = k+1 if k < DEPTH-1, else 0.
- FWD_EN=0: source hazard when a match has k < DEPTH-1. Select is always 0.
- The register file writes before it reads in the same cycle, so a slot DEPTH-1 match never needs forwarding.
- hz_stall = id_valid & !flush & (hazard on rs1 | hazard on rs2).
- Advance when freeze=0:
  - slot[i] <= slot[i-1] for i ≥ 1.
  - slot[0] <= {1, id_rd, id_we & (id_rd!=0), id_load} if id_valid & !hz_stall & !flush; otherwise bubble (valid=0).
  - fwd_a/fwd_b <= computed selects when a real instruction enters slot 0, else 0.
- freeze=1: slots, fwd_a/fwd_b and stall_cnt hold. hz_stall is still driven combinationally.
- flush overrides any hazard: no stall, bubble enters EX.
- stall_cnt increments when hz_stall & !freeze and holds at 0xFFFF_FFFF.

## Timing
- Reset: all slots invalid; fwd_a=fwd_b=0; stall_cnt=0. hz_stall=0 as a consequence.
- hz_stall: zero-cycle, combinational from decode fields and slot state. No combinational path from flush to fwd_*.
- fwd_*: valid in the cycle the instruction is in EX, one clock after it leaves decode.
- Load-use stall length = max(0, LOAD_LAT) cycles with FWD_EN=1. Back-to-back dependency stall = DEPTH-1 cycles with FWD_EN=0.
- Simultaneous flush and freeze: freeze wins. Flush is sampled again on the next unfrozen cycle; the EX stage holds flush asserted.
- rst during an active stall: next cycle all slots are empty and hz_stall=0.

## Structure
- Package hz_pkg holds:
  - slot_t struct {valid, rd[4:0], we, load};
  - REG_AW=5;
  - helper function ready_stage(load, LOAD_LAT).
- Sub-module hz_match: combinational youngest-match priority finder over the slot vector. Inputs are a source address and its use bit; outputs are hit, slot index, and producer-is-load. Instantiated twice, for rs1 and rs2.
- Top level holds the slot shift register, the stall/select logic, the fwd registers and the counter.

## Test plan
- DEPTH=3, LOAD_LAT=1, FWD_EN=1. add x5 then add x6,x5,x1 -> hz_stall=0; fwd_a=1 when consumer is in EX.
- Same config, lw x5 then add x6,x5,x1 -> hz_stall=1 for exactly 1 cycle; consumer enters EX with fwd_a=2; stall_cnt=1.
- Producers x5 at distance 2 and 3 -> fwd=2 and fwd=0 respectively. Two in-flight writers of x5 -> youngest chosen. rd=x0 or rs=x0 never stalls or forwards.
- Load-use pending with flush=1 in the same cycle -> hz_stall=0; slot 0 becomes a bubble; fwd_*=0 next cycle.
- freeze=1 for 4 cycles during a load-use stall -> slots, fwd_* and stall_cnt unchanged; the stall resolves 1 unfrozen cycle after release.
- FWD_EN=0, add x5 then sub x7,x5,x5 -> hz_stall=1 for 2 cycles, fwd_a=fwd_b=0. With LOAD_LAT=2, FWD_EN=1, a load-use stalls 2 cycles.
